// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive-side 4-slot TDM demultiplexer.
//
// Takes one sample per din_valid cycle, four slots per frame, with fsync
// marking slot 0. Slots 0..2 are held in shadow registers. When slot 3 is
// accepted, all four channel outputs load together, so a consumer never sees
// a mix of two frames. Framing violations raise a one-cycle sync_err.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   din         TDM sample for the current slot
//   din_valid   din is valid; exactly one slot is consumed per valid cycle
//   fsync       qualified by din_valid; marks the current sample as slot 0
//   ch0..ch3    demultiplexed channel samples, held between frames
//   frame_valid one-cycle pulse: ch0..ch3 took a new frame on the last edge
//   slot        slot index the next valid sample will occupy
//   locked      high while frame alignment is established
//   sync_err    one-cycle pulse on a framing violation
//
// States:
//   HUNT   | waiting for an fsync-marked sample; unsynced samples are dropped
//   LOCKED | aligned; collecting slots and checking fsync placement

module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             fsync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow0;
  logic [WIDTH-1:0] shadow1;
  logic [WIDTH-1:0] shadow2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      shadow0     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      ch0         <= '0;
      ch1         <= '0;
      ch2         <= '0;
      ch3         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      slot        <= 2'd0;
      locked      <= 1'b0;
    end else begin
      // Both strobes are single-cycle pulses by default.
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;

      if (din_valid) begin
        unique case (state)
          HUNT: begin
            if (fsync) begin
              shadow0 <= din;
              slot    <= 2'd1;
              state   <= LOCKED;
              locked  <= 1'b1;
            end
          end

          LOCKED: begin
            if (slot == 2'd0) begin
              if (fsync) begin
                shadow0 <= din;
                slot    <= 2'd1;
              end else begin
                // Missing sync: alignment is lost, so drop the sample and hunt.
                sync_err <= 1'b1;
                state    <= HUNT;
                locked   <= 1'b0;
                slot     <= 2'd0;
              end
            end else if (fsync) begin
              // Early sync: abandon the partial frame and treat this sample
              // as the start of a new one without leaving LOCKED.
              sync_err <= 1'b1;
              shadow0  <= din;
              slot     <= 2'd1;
            end else begin
              unique case (slot)
                2'd1: begin
                  shadow1 <= din;
                  slot    <= 2'd2;
                end
                2'd2: begin
                  shadow2 <= din;
                  slot    <= 2'd3;
                end
                default: begin
                  // Slot 3 completes the frame; din goes straight to ch3.
                  ch0         <= shadow0;
                  ch1         <= shadow1;
                  ch2         <= shadow2;
                  ch3         <= din;
                  frame_valid <= 1'b1;
                  slot        <= 2'd0;
                end
              endcase
            end
          end

          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            slot   <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             fsync;
  logic [WIDTH-1:0] ch0, ch1, ch2, ch3;
  logic             frame_valid;
  logic [1:0]       slot;
  logic             locked;
  logic             sync_err;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .fsync       (fsync),
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       dv;
    logic       fs;
    logic [7:0] din;
    logic [7:0] c0, c1, c2, c3;
    logic       fv;
    logic [1:0] sl;
    logic       lk;
    logic       er;
  } vec_t;

  vec_t vecs[$];
  int   applied     = 0;
  int   miscompares = 0;

  task automatic add(input logic r, input logic dv, input logic fs, input logic [7:0] d,
                     input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                     input logic [7:0] c3, input logic fv, input logic [1:0] sl,
                     input logic lk, input logic er);
    vec_t v;
    v.rst_n = r; v.dv = dv; v.fs = fs; v.din = d;
    v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3;
    v.fv = fv; v.sl = sl; v.lk = lk; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %0h, want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input vec_t v);
    applied++;
    chk("ch0", idx, 32'(ch0), 32'(v.c0));
    chk("ch1", idx, 32'(ch1), 32'(v.c1));
    chk("ch2", idx, 32'(ch2), 32'(v.c2));
    chk("ch3", idx, 32'(ch3), 32'(v.c3));
    chk("frame_valid", idx, 32'(frame_valid), 32'(v.fv));
    chk("slot", idx, 32'(slot), 32'(v.sl));
    chk("locked", idx, 32'(locked), 32'(v.lk));
    chk("sync_err", idx, 32'(sync_err), 32'(v.er));
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    rst_n     = v.rst_n;
    din_valid = v.dv;
    fsync     = v.fs;
    din       = v.din;
    @(posedge clk);
    #1;
    check_outputs(idx, v);
  endtask

  initial begin
    vec_t z;
    rst_n = 1'b0; din_valid = 1'b0; fsync = 1'b0; din = '0;

    // rst dv fs din     ch0    ch1    ch2    ch3   fv slot lk er
    // Reset then lock
    add(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 1, 1, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0);
    add(1, 1, 0, 8'hB2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 1, 0);
    add(1, 1, 0, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 0, 3, 1, 0);
    add(1, 1, 0, 8'hD4, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1, 0, 1, 0);
    add(1, 0, 0, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 0, 1, 0);
    // Gapped stream; an idle cycle with fsync/din toggling must be ignored
    add(1, 1, 1, 8'hA1, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 1, 0);
    add(1, 0, 1, 8'hEE, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 1, 0);
    add(1, 0, 0, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 1, 0);
    add(1, 1, 0, 8'hB2, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 2, 1, 0);
    add(1, 0, 0, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 2, 1, 0);
    add(1, 0, 0, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 2, 1, 0);
    add(1, 1, 0, 8'hC3, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 3, 1, 0);
    add(1, 0, 0, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 3, 1, 0);
    add(1, 0, 0, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 3, 1, 0);
    add(1, 1, 0, 8'hD4, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1, 0, 1, 0);
    add(1, 0, 0, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 0, 1, 0);
    // Hunt discard after reset
    add(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 1, 1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0);
    add(1, 1, 0, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 1, 0);
    add(1, 1, 0, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 0, 3, 1, 0);
    add(1, 1, 0, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 1, 0, 1, 0);
    // Early sync, back-to-back with the previous frame
    add(1, 1, 1, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 0, 1, 1, 0);
    add(1, 1, 0, 8'h22, 8'h01, 8'h02, 8'h03, 8'h04, 0, 2, 1, 0);
    add(1, 1, 1, 8'h33, 8'h01, 8'h02, 8'h03, 8'h04, 0, 1, 1, 1);
    add(1, 1, 0, 8'h44, 8'h01, 8'h02, 8'h03, 8'h04, 0, 2, 1, 0);
    add(1, 1, 0, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 0, 3, 1, 0);
    add(1, 1, 0, 8'h66, 8'h33, 8'h44, 8'h55, 8'h66, 1, 0, 1, 0);
    // Missing sync, then relock
    add(1, 1, 0, 8'h77, 8'h33, 8'h44, 8'h55, 8'h66, 0, 0, 0, 1);
    add(1, 1, 0, 8'h88, 8'h33, 8'h44, 8'h55, 8'h66, 0, 0, 0, 0);
    add(1, 1, 1, 8'h91, 8'h33, 8'h44, 8'h55, 8'h66, 0, 1, 1, 0);
    add(1, 1, 0, 8'h92, 8'h33, 8'h44, 8'h55, 8'h66, 0, 2, 1, 0);
    add(1, 1, 0, 8'h93, 8'h33, 8'h44, 8'h55, 8'h66, 0, 3, 1, 0);
    add(1, 1, 0, 8'h94, 8'h91, 8'h92, 8'h93, 8'h94, 1, 0, 1, 0);
    add(1, 0, 0, 8'h00, 8'h91, 8'h92, 8'h93, 8'h94, 0, 0, 1, 0);

    #1;
    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Mid-frame reset: lock, accept slots 0..2, then reset between edges.
    apply(100, '{1, 1, 1, 8'hE1, 8'h91, 8'h92, 8'h93, 8'h94, 0, 1, 1, 0});
    apply(101, '{1, 1, 0, 8'hE2, 8'h91, 8'h92, 8'h93, 8'h94, 0, 2, 1, 0});
    apply(102, '{1, 1, 0, 8'hE3, 8'h91, 8'h92, 8'h93, 8'h94, 0, 3, 1, 0});
    @(negedge clk);
    din_valid = 1'b0;
    fsync     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    z = '{0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0};
    check_outputs(103, z);
    apply(104, '{1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0});
    apply(105, '{1, 1, 1, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0});
    apply(106, '{1, 1, 0, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 1, 0});
    apply(107, '{1, 1, 0, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 0, 3, 1, 0});
    apply(108, '{1, 1, 0, 8'h0D, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1, 0, 1, 0});
    apply(109, '{1, 0, 0, 8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 0, 0, 1, 0});

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
